uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO and a fractional baud generator. It serialises queued bytes onto a single `uart_tx` line, with configurable data width, parity and stop-bit count. The producer side is a valid/ready handshake, so the CPU/bus side can queue several characters without waiting on the line. It supersedes the fixed 8N2, unbuffered transmitter in the peripheral block.

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Producer-side write handshake for uart_tx_fifo: a word moves on any
// clock edge where wr_valid and wr_ready are both high.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a transmit FIFO and a fractional
// (accumulator based) baud generator. Frames are sent back to back while
// the FIFO holds words.
//
// state    | meaning
// S_IDLE   | line idle high, waiting for a queued word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit
// S_STOP   | stop bit(s), high; chains straight into the next start bit
module uart_tx_fifo #(
    parameter int SYSCLK_FREQ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_fifo_if.slave               wr,
    output logic                        uart_tx,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [32:0] FREQ      = 33'(SYSCLK_FREQ);
    localparam logic [32:0] BAUD      = 33'(BAUD_RATE);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    logic [31:0]          acc;
    logic [32:0]          nxt;
    logic                 tick;
    logic [31:0]          acc_next;

    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;

    assign full        = (fifo_count == DEPTH_C);
    assign empty       = (fifo_count == '0);
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full;
    assign head        = mem[rd_ptr];
    // Parity is fixed when the word is loaded so the shifter can be consumed freely.
    assign head_par    = (PARITY == 1) ? ~^head : ^head;

    // A pop only happens when the FSM starts a frame: from idle, or on the
    // final stop tick when another word is waiting.
    assign pop = !empty && ((state == S_IDLE) ||
                            ((state == S_STOP) && tick && (stop_cnt == 1'b0)));

    // Remainder spreading: wide enough that acc + BAUD never overflows.
    assign nxt      = {1'b0, acc} + BAUD;
    assign tick     = (nxt >= FREQ);
    assign acc_next = tick ? 32'(nxt - FREQ) : nxt[31:0];

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    // Frame sequencer, baud accumulator and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    acc     <= '0;
                    uart_tx <= 1'b1;
                    if (!empty) begin
                        shift   <= head;
                        par_bit <= head_par;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    acc <= acc_next;
                    if (tick) begin
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= LAST_BIT;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    acc <= acc_next;
                    if (tick) begin
                        if (bit_cnt != 3'd0) begin
                            uart_tx <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (PARITY != 0) begin
                            uart_tx <= par_bit;
                            state   <= S_PARITY;
                        end else begin
                            uart_tx  <= 1'b1;
                            stop_cnt <= STOP_LAST;
                            state    <= S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    acc <= acc_next;
                    if (tick) begin
                        uart_tx  <= 1'b1;
                        stop_cnt <= STOP_LAST;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    acc <= acc_next;
                    if (tick) begin
                        if (stop_cnt != 1'b0) begin
                            stop_cnt <= 1'b0;
                        end else begin
                            frame_done <= 1'b1;
                            if (!empty) begin
                                acc     <= '0;
                                shift   <= head;
                                par_bit <= head_par;
                                uart_tx <= 1'b0;
                                state   <= S_START;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    acc     <= '0;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1 integer baud, 7O2
// fractional baud with a 4-deep FIFO, 5E1 with a 2-deep FIFO) run side by
// side. Each is driven with random pushes and compared every cycle with a
// queue-based model that places bit i of a frame at cycle ceil(i*F/B).
module tb_uart_tx_fifo;
    logic clk;
    int   n_chk = 0;
    int   n_err = 0;

    localparam logic [2:0][31:0] P_FREQ  = {32'd7,    32'd10,   32'd16};
    localparam logic [2:0][31:0] P_BAUD  = {32'd2,    32'd3,    32'd1};
    localparam logic [2:0][31:0] P_DB    = {32'd5,    32'd7,    32'd8};
    localparam logic [2:0][31:0] P_PAR   = {32'd2,    32'd1,    32'd0};
    localparam logic [2:0][31:0] P_STOP  = {32'd1,    32'd2,    32'd1};
    localparam logic [2:0][31:0] P_DEPTH = {32'd2,    32'd4,    32'd16};
    localparam logic [2:0][31:0] P_FIRST = {32'h15,   32'h03,   32'hA5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int F     = int'(P_FREQ[g]);
        localparam int B     = int'(P_BAUD[g]);
        localparam int DB    = int'(P_DB[g]);
        localparam int PAR   = int'(P_PAR[g]);
        localparam int SB    = int'(P_STOP[g]);
        localparam int DEPTH = int'(P_DEPTH[g]);
        localparam int FIRST = int'(P_FIRST[g]);
        localparam int CW    = $clog2(DEPTH) + 1;
        localparam int FLEN  = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
        localparam int TEND  = (FLEN * F + B - 1) / B;
        localparam int TMID  = (2 * F + B - 1) / B;

        logic          rst_g;
        logic          tx;
        logic          bsy;
        logic          fdone;
        logic [CW-1:0] cnt;

        uart_tx_fifo_if #(.DATA_BITS(DB)) bus ();

        uart_tx_fifo #(
            .SYSCLK_FREQ(F),
            .BAUD_RATE  (B),
            .DATA_BITS  (DB),
            .PARITY     (PAR),
            .STOP_BITS  (SB),
            .FIFO_DEPTH (DEPTH)
        ) dut (
            .clk       (clk),
            .rst       (rst_g),
            .wr        (bus.slave),
            .uart_tx   (tx),
            .busy      (bsy),
            .frame_done(fdone),
            .fifo_count(cnt)
        );

        int q[$];
        bit act      = 1'b0;
        int t        = 0;
        int cur      = 0;
        bit fd_m     = 1'b0;
        bit seen_rst = 1'b0;
        bit can_pop;
        bit do_push;
        bit done     = 1'b0;
        int fd_cnt   = 0;
        int pushes_m = 0;

        // Line level expected t cycles after a frame's start edge.
        function automatic int exp_bit(input int tt, input int w);
            int i = 0;
            while ((((i + 1) * F) + B - 1) / B <= tt) i++;
            if (i == 0) return 0;
            if (i <= DB) return (w >> (i - 1)) & 1;
            if (PAR != 0 && i == DB + 1) begin
                if (PAR == 1) return ($countones(w) % 2 == 0) ? 1 : 0;
                return $countones(w) % 2;
            end
            return 1;
        endfunction

        // Reference model: queue of words plus position within the current frame.
        always @(posedge clk) begin
            if (fdone === 1'b1) fd_cnt++;
            if (rst_g) begin
                q.delete();
                act      = 1'b0;
                t        = 0;
                fd_m     = 1'b0;
                seen_rst = 1'b1;
            end else begin
                can_pop = (q.size() != 0);
                do_push = bus.wr_valid && (q.size() < DEPTH);
                fd_m    = 1'b0;
                if (act) begin
                    t++;
                    if (t == TEND) begin
                        fd_m = 1'b1;
                        act  = 1'b0;
                    end
                end
                if (!act && can_pop) begin
                    cur = q.pop_front();
                    act = 1'b1;
                    t   = 0;
                end
                if (do_push) begin
                    q.push_back(int'(bus.wr_data));
                    pushes_m++;
                end
            end
        end

        // Cycle-by-cycle comparison against the model, away from the active edge.
        always @(negedge clk) begin
            if (seen_rst) begin
                chk($sformatf("i%0d.uart_tx", g), 32'(tx),
                    act ? 32'(exp_bit(t, cur)) : 32'd1);
                chk($sformatf("i%0d.busy", g), 32'(bsy), 32'(act));
                chk($sformatf("i%0d.frame_done", g), 32'(fdone), 32'(fd_m));
                chk($sformatf("i%0d.fifo_count", g), 32'(cnt), 32'(q.size()));
                chk($sformatf("i%0d.wr_ready", g), 32'(bus.wr_ready), 32'(q.size() < DEPTH));
            end
        end

        task automatic wait_idle(input int budget, input string tag);
            int c = 0;
            while ((bsy || cnt != '0) && c < budget) begin
                @(negedge clk);
                c++;
            end
            @(negedge clk);
            chk($sformatf("i%0d.%s_busy", g, tag), 32'(bsy), 32'd0);
            chk($sformatf("i%0d.%s_count", g, tag), 32'(cnt), 32'd0);
        endtask

        initial begin
            int c;
            rst_g        = 1'b1;
            bus.wr_valid = 1'b0;
            bus.wr_data  = '0;
            repeat (3) @(negedge clk);
            rst_g = 1'b0;

            bus.wr_valid = 1'b1;
            bus.wr_data  = DB'(FIRST);
            @(negedge clk);
            bus.wr_valid = 1'b0;
            wait_idle(TEND + 20, "first");
            chk($sformatf("i%0d.first_frames", g), 32'(fd_cnt), 32'd1);

            for (c = 0; c < 600; c++) begin
                bus.wr_valid = ($urandom_range(0, 9) < 7);
                bus.wr_data  = DB'($urandom);
                @(negedge clk);
            end
            bus.wr_valid = 1'b0;
            wait_idle((DEPTH + 2) * TEND + 50, "drain");
            chk($sformatf("i%0d.frame_total", g), 32'(fd_cnt), 32'(pushes_m));

            bus.wr_valid = 1'b1;
            for (c = 0; c < 4; c++) begin
                bus.wr_data = DB'($urandom);
                @(negedge clk);
            end
            bus.wr_valid = 1'b0;
            c = 0;
            while (!(bsy && cnt != '0 && t >= TMID) && c < 4 * TEND) begin
                @(negedge clk);
                c++;
            end
            chk($sformatf("i%0d.mid_busy", g), 32'(bsy), 32'd1);
            chk($sformatf("i%0d.mid_queued", g), 32'(cnt != '0), 32'd1);
            rst_g = 1'b1;
            @(negedge clk);
            chk($sformatf("i%0d.rst_tx", g), 32'(tx), 32'd1);
            chk($sformatf("i%0d.rst_count", g), 32'(cnt), 32'd0);
            chk($sformatf("i%0d.rst_busy", g), 32'(bsy), 32'd0);
            rst_g = 1'b0;
            repeat (2 * TEND) @(negedge clk);
            chk($sformatf("i%0d.post_rst_tx", g), 32'(tx), 32'd1);
            chk($sformatf("i%0d.post_rst_busy", g), 32'(bsy), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk);
            if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
        end
        chk("all_done", {29'd0, g_inst[2].done, g_inst[1].done, g_inst[0].done}, 32'd7);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
